// File: rtl/riscv_imem_loader.sv
// Boot-time program loader for the single-cycle RISC-V core.
// Packs an incoming byte stream little-endian into 32-bit words. Each word is
// written to instruction memory at consecutive word addresses starting at 0.
// The core is held in reset until the requested number of words has landed.
module riscv_imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int LEN_W       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_wdata_o,
    output logic             core_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt_q;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      buf_q;

    // Registered copies of every output; nothing reaches a port combinationally.
    logic             byte_ready_q;
    logic             imem_we_q;
    logic [31:0]      imem_addr_q;
    logic [31:0]      imem_wdata_q;
    logic             core_rst_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Next-state helpers derived from current registers and inputs.
    logic [31:0]      buf_d;
    logic [LEN_W-1:0] word_cnt_d;
    logic             len_legal;

    // A length is usable only if it is non-zero and fits in the memory.
    assign len_legal  = (len_i != '0) && (len_i <= LEN_W'(DEPTH_WORDS));
    assign word_cnt_d = word_cnt_q + LEN_W'(1);

    // Byte-lane steering: only the lane selected by the byte counter takes
    // the incoming byte, the other lanes keep what they already hold. When
    // the 4th byte arrives, buf_d is the complete word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign buf_d[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? byte_i
                                                              : buf_q[8*gi +: 8];
        end
    endgenerate

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            imem_we_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    core_rst_q <= 1'b1;
                    if (start_i) begin
                        if (len_legal) begin
                            len_q        <= len_i;
                            word_cnt_q   <= '0;
                            byte_cnt_q   <= '0;
                            err_q        <= 1'b0;
                            state_q      <= ST_LOAD;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    // A bubble leaves everything untouched.
                    if (byte_valid_i) begin
                        buf_q      <= buf_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Word complete: present it to memory next cycle.
                            state_q      <= ST_WRITE;
                            byte_ready_q <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= 32'({word_cnt_q, 2'b00});
                            imem_wdata_q <= buf_d;
                        end
                    end
                end

                ST_WRITE: begin
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == len_q) begin
                        // Last word written this cycle; release the core.
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b0;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q      <= ST_LOAD;
                        byte_ready_q <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (start_i) begin
                        if (len_legal) begin
                            // Reload: put the core back into reset first.
                            len_q        <= len_i;
                            word_cnt_q   <= '0;
                            byte_cnt_q   <= '0;
                            err_q        <= 1'b0;
                            state_q      <= ST_LOAD;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            core_rst_q   <= 1'b1;
                            done_q       <= 1'b0;
                        end else begin
                            // Bad request is flagged but the core keeps running.
                            err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign core_rst_o   = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/riscv_imem_loader.md
# riscv_imem_loader

Boot-time program loader directly upstream of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Each word is written into instruction memory at consecutive word addresses starting at 0. The core is held in reset through `core_rst_o` until the programmed word count has been written, then released.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: instruction memory capacity in 32-bit words.
- `LEN_W`, 9: width of `len_i`; must satisfy 2^LEN_W > DEPTH_WORDS.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  single-cycle load request.
- `len_i`  in  LEN_W  program length in words; sampled only when `start_i` is accepted.
- `byte_i`  in  8  program byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `imem_we_o`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr_o`  out  32  byte address of the word being written (word index × 4).
- `imem_wdata_o`  out  32  assembled word.
- `core_rst_o`  out  1  reset to the core (high = core held in reset).
- `busy_o`  out  1  load in progress.
- `done_o`  out  1  program loaded and core running.
- `err_o`  out  1  last `start_i` had an illegal `len_i`; sticky.

## Operation
- States: IDLE, LOAD, WRITE, RUN.
- Reset values:
  - state = IDLE.
  - `core_rst_o` = 1.
  - `byte_ready_o`, `imem_we_o`, `busy_o`, `done_o`, `err_o` = 0.
  - `imem_addr_o` = 0, `imem_wdata_o` = 0.
  - Word counter, byte counter and assembly buffer = 0.
- IDLE: `core_rst_o` = 1.
  - `start_i` with 1 ≤ `len_i` ≤ DEPTH_WORDS: latch `len_i`, clear both counters and `err_o`, go to LOAD.
  - `start_i` with `len_i` = 0 or `len_i` > DEPTH_WORDS: set `err_o`, stay in IDLE.
- LOAD: `byte_ready_o` = 1 and `busy_o` = 1.
  - On each transfer (`byte_valid_i` & `byte_ready_o`), write the byte to buffer bits [8k+7:8k], where k is the 2-bit byte counter, then increment k.
  - On the transfer with k = 3, go to WRITE.
  - `start_i` is ignored in LOAD and WRITE.
- WRITE: `byte_ready_o` = 0, `busy_o` = 1.
  - Drive `imem_we_o` = 1 for exactly one cycle, with `imem_addr_o` = word_cnt << 2 and `imem_wdata_o` = buffer.
  - Increment word_cnt.
  - If the incremented word_cnt equals the latched length, go to RUN; otherwise go to LOAD.
- RUN: `core_rst_o` = 0, `done_o` = 1, `busy_o` = 0.
  - `start_i` with a legal `len_i`: assert `core_rst_o` on the next cycle, clear `done_o`, go to LOAD (reload).
  - `start_i` with an illegal `len_i`: set `err_o` and stay in RUN, with the core still running.
- Width rules:
  - word_cnt is LEN_W bits; the address is zero-extended to 32 bits.
  - The byte counter is 2 bits and wraps 3→0.
- A bubble (`byte_valid_i` = 0) in LOAD holds all state.
- `rst` at any point returns every register to its reset value immediately. A partial program in memory is left as is and is not cleaned up.

## Timing
- All outputs are registered; none is combinationally driven from inputs.
- `byte_ready_o` depends only on state; it is high in every LOAD cycle.
- Word latency: 4th byte accepted in cycle n → `imem_we_o` high in cycle n+1 → `byte_ready_o` high again in cycle n+2.
- Maximum throughput: one word per 5 cycles.
- Release: the last WRITE in cycle m → `core_rst_o` = 0 and `done_o` = 1 from cycle m+1. The core's first fetch at PC 0 sees the fully written memory.
- Start acceptance: `start_i` in cycle s → `byte_ready_o` high in cycle s+1.
- `err_o` rises in cycle s+1 and stays set until a legal `start_i` is accepted.

## Test plan
- Reset then `start_i` with `len_i` = 2, bytes 0x13,0x05,0x10,0x00,0xB7,0x02,0x00,0x00 back-to-back → writes 0x00100513 @0x0 and 0x000002B7 @0x4. `core_rst_o` falls the cycle after the 2nd write; `done_o` = 1.
- Same stream with `byte_valid_i` toggling 1/0 → identical writes; no byte dropped or duplicated; `imem_we_o` is high exactly 2 cycles in total.
- `start_i` with `len_i` = 0, then with `len_i` = DEPTH_WORDS+1 → `err_o` = 1, state stays IDLE, `byte_ready_o` = 0. A following legal start clears `err_o`.
- Load `len_i` = DEPTH_WORDS → the last write is at address (DEPTH_WORDS−1)×4, with no wrap to 0.
- In RUN, pulse `start_i` with `len_i` = 1 → `core_rst_o` = 1 the next cycle; reload writes @0x0; the core is released again.
- Assert `rst` after 3 bytes of word 1 → all outputs return to their reset values asynchronously. A new load starts with a byte counter of 0.
